// File: rtl/bubblesort_stream_pkg.sv
// bubblesort_stream_pkg: shared types and constants for the sorter stream adapter.
// Holds the FSM state encoding, index-width helper and default sorter geometry.
package bubblesort_stream_pkg;

   localparam int N_BITS_DEF         = 8;
   localparam int K_NUMBERS_DEF      = 49;
   localparam int TIMEOUT_CYCLES_DEF = 4096;

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      START  = 2'd1,
      WAIT   = 2'd2,
      UNLOAD = 2'd3
   } state_e;

   // slot index width, never below one bit
   function automatic int idx_w(input int k);
      return (k > 1) ? $clog2(k) : 1;
   endfunction

endpackage

// File: rtl/bubblesort_stream_ctrl_if.sv
// bubblesort_stream_ctrl_if: input and output valid/ready word streams.
// slave = adapter side, master = bus master / DMA side.
interface bubblesort_stream_ctrl_if #(
   parameter int N_BITS = 8
) ();

   logic [N_BITS-1:0] in_data_i;
   logic              in_valid_i;
   logic              in_ready_o;
   logic [N_BITS-1:0] out_data_o;
   logic              out_valid_o;
   logic              out_last_o;
   logic              out_ready_i;

   modport slave (
      input  in_data_i, in_valid_i, out_ready_i,
      output in_ready_o, out_data_o, out_valid_o, out_last_o
   );

   modport master (
      output in_data_i, in_valid_i, out_ready_i,
      input  in_ready_o, out_data_o, out_valid_o, out_last_o
   );

endinterface

// File: rtl/bubblesort_unload_buf.sv
// bubblesort_unload_buf: capture buffer for the sorted vector plus output register.
// Ports: capture_i/rdata_i load the frame, idx_i is the word on show, out_* stream, hs_o handshake.
module bubblesort_unload_buf
   import bubblesort_stream_pkg::*;
#(
   parameter int N_BITS    = N_BITS_DEF,
   parameter int K_NUMBERS = K_NUMBERS_DEF,
   parameter int IW        = idx_w(K_NUMBERS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        capture_i,
   input  logic [K_NUMBERS*N_BITS-1:0] rdata_i,
   input  logic [IW-1:0]               idx_i,
   input  logic                        out_ready_i,
   output logic [N_BITS-1:0]           out_data_o,
   output logic                        out_valid_o,
   output logic                        out_last_o,
   output logic                        hs_o
);

   localparam int IW1 = IW + 1;

   logic [K_NUMBERS*N_BITS-1:0] buf_q, buf_d;
   logic [N_BITS-1:0]           data_q, data_d;
   logic                        valid_q, valid_d;
   logic                        last_q, last_d;
   logic [IW:0]                 nxt;

   assign hs_o = valid_q & out_ready_i;
   assign nxt  = {1'b0, idx_i} + 1'b1;

   always_comb begin
      buf_d   = buf_q;
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      if (capture_i) begin
         // slot 0 goes straight to the output so valid follows done by one cycle
         buf_d   = rdata_i;
         data_d  = rdata_i[N_BITS-1:0];
         valid_d = 1'b1;
         last_d  = (K_NUMBERS == 1);
      end else if (hs_o) begin
         if (last_q) begin
            valid_d = 1'b0;
         end else begin
            for (int i = 0; i < K_NUMBERS; i++) begin
               if (nxt == IW1'(i)) data_d = buf_q[i*N_BITS +: N_BITS];
            end
            last_d = (nxt == IW1'(K_NUMBERS - 1));
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         buf_q   <= buf_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   assign out_data_o  = data_q;
   assign out_valid_o = valid_q;
   assign out_last_o  = last_q;

endmodule

// File: rtl/bubblesort_stream_ctrl.sv
// bubblesort_stream_ctrl: streams K_NUMBERS words into the sorter, starts it, streams result out.
// Ports: clk/rst, stream if s, busy_o, sort_* sorter bus, error_o. Macro SORT_WATCHDOG_EN adds WAIT watchdog.
module bubblesort_stream_ctrl
   import bubblesort_stream_pkg::*;
#(
   parameter int N_BITS         = N_BITS_DEF,
   parameter int K_NUMBERS      = K_NUMBERS_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   bubblesort_stream_ctrl_if.slave     s,
   output logic                        busy_o,
   output logic [K_NUMBERS-1:0]        sort_load_o,
   output logic [K_NUMBERS*N_BITS-1:0] sort_wdata_o,
   input  logic [K_NUMBERS*N_BITS-1:0] sort_rdata_i,
   output logic                        sort_start_o,
   input  logic                        sort_done_i,
   output logic                        sort_abort_o,
   output logic                        error_o
);

   localparam int            IW       = idx_w(K_NUMBERS);
   localparam logic [IW-1:0] LAST_IDX = IW'(K_NUMBERS - 1);

   state_e                      state_q, state_d;
   logic [IW-1:0]               idx_q, idx_d;
   logic [K_NUMBERS-1:0]        load_q, load_d;
   logic [K_NUMBERS*N_BITS-1:0] wdata_q, wdata_d;
   logic                        start_q, start_d;
   logic                        accept;
   logic                        capture;
   logic                        out_hs;
   logic [N_BITS-1:0]           out_data;
   logic                        out_valid;
   logic                        out_last;

   assign accept = s.in_valid_i && (state_q == LOAD);

`ifdef SORT_WATCHDOG_EN
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

   logic [WW-1:0] wd_q, wd_d;
   logic          timeout;
   logic          abort_q, abort_d;
   logic          error_q, error_d;

   // wd_q counts WAIT cycles, starting at 0 on the start-pulse cycle
   always_comb begin
      wd_d    = '0;
      timeout = 1'b0;
      if (state_q == WAIT) begin
         wd_d    = wd_q + 1'b1;
         timeout = (wd_q == WW'(TIMEOUT_CYCLES - 1));
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      load_d  = '0;
      wdata_d = wdata_q;
      start_d = 1'b0;
      capture = 1'b0;
`ifdef SORT_WATCHDOG_EN
      abort_d = 1'b0;
      error_d = error_q;
`endif
      unique case (state_q)
         LOAD: begin
            if (accept) begin
               for (int i = 0; i < K_NUMBERS; i++) begin
                  if (idx_q == IW'(i)) begin
                     load_d[i]                  = 1'b1;
                     wdata_d[i*N_BITS +: N_BITS] = s.in_data_i;
                  end
               end
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = START;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         START: begin
            start_d = 1'b1;
            state_d = WAIT;
         end
         WAIT: begin
            // done during the start pulse belongs to a stale sort
            if (sort_done_i && !start_q) begin
               capture = 1'b1;
               idx_d   = '0;
               state_d = UNLOAD;
            end
`ifdef SORT_WATCHDOG_EN
            else if (timeout) begin
               abort_d = 1'b1;
               error_d = 1'b1;
               idx_d   = '0;
               state_d = LOAD;
            end
`endif
         end
         UNLOAD: begin
            if (out_hs) begin
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = LOAD;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= LOAD;
         idx_q   <= '0;
         load_q  <= '0;
         wdata_q <= '0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         load_q  <= load_d;
         wdata_q <= wdata_d;
         start_q <= start_d;
      end
   end

`ifdef SORT_WATCHDOG_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_q    <= '0;
         abort_q <= 1'b0;
         error_q <= 1'b0;
      end else begin
         wd_q    <= wd_d;
         abort_q <= abort_d;
         error_q <= error_d;
      end
   end

   assign sort_abort_o = abort_q;
   assign error_o      = error_q;
`else
   assign sort_abort_o = 1'b0;
   assign error_o      = 1'b0;
`endif

   bubblesort_unload_buf #(
      .N_BITS    (N_BITS),
      .K_NUMBERS (K_NUMBERS)
   ) u_unload (
      .clk         (clk),
      .rst         (rst),
      .capture_i   (capture),
      .rdata_i     (sort_rdata_i),
      .idx_i       (idx_q),
      .out_ready_i (s.out_ready_i),
      .out_data_o  (out_data),
      .out_valid_o (out_valid),
      .out_last_o  (out_last),
      .hs_o        (out_hs)
   );

   assign s.in_ready_o  = (state_q == LOAD);
   assign s.out_data_o  = out_data;
   assign s.out_valid_o = out_valid;
   assign s.out_last_o  = out_last;
   assign busy_o        = !((state_q == LOAD) && (idx_q == '0));
   assign sort_load_o   = load_q;
   assign sort_wdata_o  = wdata_q;
   assign sort_start_o  = start_q;

endmodule
